// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern-scan scheduler and its 1101 detector.
// Build option SCAN_OVERLAP_EN selects overlapping match counting in the detector.
package pattern_scan_pkg;

    localparam int unsigned PATTERN_LEN = 4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned HIT_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4
    } sched_state_e;

    typedef enum logic [2:0] {
        DET_S0 = 3'd0,
        DET_S1 = 3'd1,
        DET_S2 = 3'd2,
        DET_S3 = 3'd3,
        DET_S4 = 3'd4
    } det_state_e;

    // Detector state index equals the number of pattern bits matched so far.
    localparam det_state_e DET_MATCH = det_state_e'(3'(PATTERN_LEN));

endpackage

// File: rtl/pattern_scan_sched_seq_detect.sv
// Moore detector for the serial pattern 1101; seen is high while in the match state.
// Build option SCAN_OVERLAP_EN: a 1 after a match continues from "11" instead of "1".
module seq_detect_1101
    import pattern_scan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic seen
);

    det_state_e state_q, state_d;
    logic       seen_q, seen_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DET_S0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
        end
    end

    // Illegal encodings fall back to S0 regardless of en.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DET_S0: if (en) state_d = bit_in ? DET_S1 : DET_S0;
            DET_S1: if (en) state_d = bit_in ? DET_S2 : DET_S0;
            DET_S2: if (en) state_d = bit_in ? DET_S2 : DET_S3;
            DET_S3: if (en) state_d = bit_in ? DET_S4 : DET_S0;
            DET_S4: if (en) begin
`ifdef SCAN_OVERLAP_EN
                state_d = bit_in ? DET_S2 : DET_S0;
`else
                state_d = bit_in ? DET_S1 : DET_S0;
`endif
            end
            default: state_d = DET_S0;
        endcase
        if (clr) state_d = DET_S0;
    end

    always_comb begin
        seen_d = (state_d == DET_MATCH);
    end

    assign seen = seen_q;

endmodule

// File: rtl/pattern_scan_sched.sv
// Round-robin scheduler that grants one requester, scans its byte MSB-first for 1101
// and reports the per-byte hit count plus a saturating running total (see SCAN_OVERLAP_EN).
module pattern_scan_sched
    import pattern_scan_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned TOT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*BYTE_W-1:0]    data,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic [HIT_W-1:0]          hit_count,
    output logic [TOT_W-1:0]          total_hits
);

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned BIT_W = $clog2(BYTE_W);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d, arb_id;
    logic              arb_found;
    logic [BYTE_W-1:0] sh_q, sh_d, sel_byte;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [HIT_W-1:0]  cnt_q, cnt_d;
    logic [TOT_W-1:0]  total_q, total_d;
    logic [TOT_W:0]    total_sum;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic [HIT_W-1:0]  hit_q, hit_d;
    logic              det_clr, det_en, det_seen;

    seq_detect_1101 u_detect (
        .clk    (clk),
        .reset  (reset),
        .clr    (det_clr),
        .en     (det_en),
        .bit_in (sh_q[BYTE_W-1]),
        .seen   (det_seen)
    );

    // Round-robin search starting at ptr_q, which holds last grant + 1.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!arb_found && req[ID_W'((32'(ptr_q) + k) % NREQ)]) begin
                arb_found = 1'b1;
                arb_id    = ID_W'((32'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (id_q == ID_W'(i)) sel_byte = data[i*BYTE_W +: BYTE_W];
        end
    end

    assign total_sum = {1'b0, total_q} + (TOT_W+1)'(hit_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|req) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SHIFT;
            ST_SHIFT:  if (bit_q == BIT_W'(BYTE_W-1)) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath updates plus look-ahead values for the registered outputs.
    always_comb begin
        ptr_d   = ptr_q;
        id_d    = id_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        det_clr = 1'b0;
        det_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    id_d  = arb_id;
                    ptr_d = (arb_id == ID_W'(NREQ-1)) ? '0 : arb_id + ID_W'(1);
                end
            end
            ST_LOAD: begin
                sh_d    = sel_byte;
                bit_d   = '0;
                cnt_d   = '0;
                det_clr = 1'b1;
            end
            ST_SHIFT: begin
                det_en = 1'b1;
                sh_d   = {sh_q[BYTE_W-2:0], 1'b0};
                bit_d  = bit_q + BIT_W'(1);
                // seen lags the fed bit by one cycle, so the first shift cycle never counts.
                if (bit_q != '0 && det_seen) cnt_d = cnt_q + HIT_W'(1);
            end
            ST_DRAIN: begin
                if (det_seen) cnt_d = cnt_q + HIT_W'(1);
            end
            ST_REPORT: begin
                total_d = total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
            end
            default: ;
        endcase

        gnt_d     = (state_d == ST_LOAD) ? (NREQ'(1) << id_d) : '0;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_REPORT);
        done_id_d = done_d ? id_q : '0;
        hit_d     = done_d ? cnt_d : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            id_q      <= '0;
            sh_q      <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            total_q   <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            hit_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            hit_q     <= hit_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_id    = done_id_q;
    assign hit_count  = hit_q;
    assign total_hits = total_q;

endmodule

// File: doc/pattern_scan_sched.md
PATTERN_SCAN_SCHED -- requirements
Module: pattern_scan_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TOT_W, default 16, width of the running total-hit counter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  NREQ  per-requester scan request, level-sensitive.
REQ-006 SHALL have port data  input  NREQ*8  packed request bytes; requester i owns bits [8i+7:8i].
REQ-007 SHALL have port gnt  output  NREQ  one-hot grant, one-cycle pulse in LOAD.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse in REPORT.
REQ-010 SHALL have port done_id  output  clog2(NREQ)  index of the scanned requester, valid with done.
REQ-011 SHALL have port hit_count  output  3  pattern occurrences in the scanned byte, valid with done.
REQ-012 SHALL have port total_hits  output  TOT_W  saturating sum of all reported hit_count values.

Function
REQ-013 SHALL implement the FSM IDLE -> LOAD -> SHIFT (8 cycles) -> DRAIN (1) -> REPORT (1) -> IDLE.
REQ-014 IDLE SHALL go to LOAD on the first edge where req is non-zero, otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: search starts at last granted index +1 modulo NREQ; the pointer is 0 after reset.
REQ-016 LOAD SHALL pulse gnt[id], capture data byte id into an 8-bit shift register, clear the detector to S0, and clear the byte hit counter.
REQ-017 SHALL ignore req changes after LOAD; the captured byte is scanned to completion.
REQ-018 SHIFT SHALL feed one bit per cycle into the detector, MSB first, bit 7 in the first SHIFT cycle.
REQ-019 The detector SHALL be a Moore FSM for serial pattern 1101 with states S0..S4; seen is 1 only in S4.
REQ-020 Transitions: S0 1->S1 0->S0; S1 1->S2 0->S0; S2 0->S3 1->S2; S3 1->S4 0->S0; S4 0->S0, 1 per REQ-029.
REQ-021 The byte hit counter SHALL increment in every SHIFT cycle after the first, and in DRAIN, when seen is 1, so a match on bit 0 is counted.
REQ-022 Matches SHALL NOT span bytes; the detector restarts at S0 for every grant.
REQ-023 REPORT SHALL assert done, drive done_id and hit_count, and add hit_count to total_hits, saturating at all-ones.
REQ-024 Grant-to-done latency SHALL be 10 cycles (LOAD at cycle 0, done at cycle 10); back-to-back scans SHALL have 1 IDLE cycle between REPORT and the next LOAD.
REQ-025 gnt, done, hit_count and done_id SHALL be 0 outside the cycles stated above.
REQ-026 An illegal detector state SHALL return to S0 on the next edge; an illegal scheduler state SHALL return to IDLE.

Reset
REQ-027 Reset SHALL force IDLE, detector S0, RR pointer 0, shift register 0, byte counter 0, and total_hits 0.
REQ-028 Reset asserted mid-scan SHALL abandon the scan with no done pulse; all outputs SHALL be 0 while reset is high.

Configuration
REQ-029 With SCAN_OVERLAP_EN defined, S4 on 1 SHALL go to S2 (overlapping matches); without it, S4 on 1 SHALL go to S1 (non-overlapping restart).

Structure
REQ-030 A shared package pattern_scan_pkg SHALL hold the scheduler state enum, the detector state enum (S0..S4), and the constant PATTERN_LEN = 4.
REQ-031 The detector SHALL be a sub-module seq_detect_1101 with ports clk, reset, clr, en, bit_in, seen; the scheduler instantiates it once.

Verification
REQ-032 Single request: req=4'b0001, data[7:0]=8'hD0 -> gnt=0001 at cycle 0, done at cycle 10, done_id=0, hit_count=1, total_hits=1.
REQ-033 Overlap: data[7:0]=8'b11011011 -> hit_count=2 with SCAN_OVERLAP_EN defined, hit_count=1 without it.
REQ-034 Round-robin: req=4'b1111 held -> grants in order 0,1,2,3,0, with one done per grant and consecutive done_id 0,1,2,3,0.
REQ-035 Tail match: data=8'b00001101 -> the match on bit 0 is counted via DRAIN, hit_count=1.
REQ-036 Reset in SHIFT cycle 4 -> no done, busy=0 while reset is high; after reset release with req=4'b0010, the next grant goes to requester 1.
REQ-037 Saturation: TOT_W=2, three scans of 8'hD0 -> total_hits is 1, 2, 3, then remains 3.
